// File: rtl/board_pkg.sv
// Shared board geometry, drawer park code and sequencer state encoding.
// Pure declarations; no timing or flow control of its own.
package board_pkg;

    localparam int NUM_TILES = 9;
    localparam int COLOUR_W  = 3;
    localparam int IDX_W     = 4;

    localparam logic [IDX_W-1:0] LOC_PARK = 4'hF;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SETTLE,
        ST_DRAW,
        ST_PARK,
        ST_DONE
    } state_t;

    function automatic logic [COLOUR_W-1:0] tile_colour(
        input logic [NUM_TILES*COLOUR_W-1:0] colours,
        input logic [IDX_W-1:0]              idx
    );
        logic [COLOUR_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (idx == IDX_W'(i)) r = colours[i*COLOUR_W +: COLOUR_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/draw_watchdog.sv
// Saturating stall counter; timeout is high on the TIMEOUT-th consecutive counted cycle.
// Counter is registered, timeout decodes it directly; no backpressure.
module draw_watchdog #(
    parameter int TIMEOUT = 2048
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = count_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/board_draw_sequencer.sv
// Snapshots a 3x3 board on start and feeds masked tiles one at a time to the tile drawer.
// All outputs registered; each tile waits on drawer_finished, bounded by a TIMEOUT watchdog.
module board_draw_sequencer
    import board_pkg::*;
#(
    parameter int TIMEOUT = 2048
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [NUM_TILES*COLOUR_W-1:0] tile_colours,
    input  logic [NUM_TILES-1:0]          redraw_mask,
    input  logic                          drawer_finished,
    output logic                          drawer_enable,
    output logic [IDX_W-1:0]              drawer_location,
    output logic [COLOUR_W-1:0]           drawer_colour,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NUM_TILES*COLOUR_W-1:0] colours_q, colours_d;
    logic [NUM_TILES-1:0]          mask_q, mask_d;
    logic                          enable_q, enable_d;
    logic [IDX_W-1:0]              loc_q, loc_d;
    logic [COLOUR_W-1:0]           colour_q, colour_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          error_q, error_d;

    logic wd_clear, wd_count, wd_timeout;

    assign wd_count = (state_q == ST_DRAW);
    assign wd_clear = !wd_count;

    draw_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (wd_clear),
        .count_en (wd_count),
        .timeout  (wd_timeout)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        colours_d = colours_q;
        mask_d    = mask_q;
        enable_d  = enable_q;
        loc_d     = loc_q;
        colour_d  = colour_q;
        error_d   = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    colours_d = tile_colours;
                    mask_d    = redraw_mask;
                    idx_d     = '0;
                    error_d   = 1'b0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (mask_q[idx_q]) begin
                    loc_d    = idx_q;
                    colour_d = tile_colour(colours_q, idx_q);
                    state_d  = ST_SETTLE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                enable_d = 1'b1;
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                // finished is checked first so a same-cycle timeout never flags an error
                if (drawer_finished) begin
                    enable_d = 1'b0;
                    loc_d    = LOC_PARK;
                    state_d  = ST_PARK;
                end else if (wd_timeout) begin
                    error_d  = 1'b1;
                    enable_d = 1'b0;
                    loc_d    = LOC_PARK;
                    state_d  = ST_PARK;
                end
            end
            ST_PARK: begin
                enable_d = 1'b0;
                loc_d    = LOC_PARK;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                enable_d = 1'b0;
                loc_d    = LOC_PARK;
                state_d  = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            colours_q <= '0;
            mask_q    <= '0;
            enable_q  <= 1'b0;
            loc_q     <= LOC_PARK;
            colour_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            colours_q <= colours_d;
            mask_q    <= mask_d;
            enable_q  <= enable_d;
            loc_q     <= loc_d;
            colour_q  <= colour_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign drawer_enable   = enable_q;
    assign drawer_location = loc_q;
    assign drawer_colour   = colour_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_board_draw_sequencer.sv
// Bench for board_draw_sequencer: scoreboard of expected tile draws checked on each enable rise.
module tb_board_draw_sequencer;

    localparam int DRAW_CYC = 1296;

    typedef struct {
        logic [3:0] loc;
        logic [2:0] col;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;

    logic        start;
    logic [26:0] tile_colours;
    logic [8:0]  redraw_mask;
    logic        en, busy, done, err;
    logic [3:0]  loc;
    logic [2:0]  col;

    logic        start2;
    logic [26:0] tile_colours2;
    logic [8:0]  redraw_mask2;
    logic        fin2;
    logic        en2, busy2, done2, err2;
    logic [3:0]  loc2;
    logic [2:0]  col2;

    logic        m_fin = 1'b0;
    int          m_cnt = 0;
    logic [3:0]  m_prev_loc = 4'hF;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    logic en_prev = 1'b0;
    logic en2_prev = 1'b0;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    board_draw_sequencer u_dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .tile_colours    (tile_colours),
        .redraw_mask     (redraw_mask),
        .drawer_finished (m_fin),
        .drawer_enable   (en),
        .drawer_location (loc),
        .drawer_colour   (col),
        .busy            (busy),
        .done            (done),
        .error           (err)
    );

    board_draw_sequencer #(.TIMEOUT(16)) u_dut_to (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start2),
        .tile_colours    (tile_colours2),
        .redraw_mask     (redraw_mask2),
        .drawer_finished (fin2),
        .drawer_enable   (en2),
        .drawer_location (loc2),
        .drawer_colour   (col2),
        .busy            (busy2),
        .done            (done2),
        .error           (err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drawer model: finishes DRAW_CYC enabled cycles after a location change.
    always @(posedge clk) begin
        m_prev_loc <= loc;
        if (loc != m_prev_loc) begin
            m_cnt <= 0;
            m_fin <= 1'b0;
        end else if (en && !m_fin) begin
            if (m_cnt == DRAW_CYC - 1) m_fin <= 1'b1;
            else m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (en && !en_prev) begin
                check("sb_has_entry", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("tile_loc", 32'(loc), 32'(e.loc));
                    check("tile_col", 32'(col), 32'(e.col));
                end
            end
            if (!en && en_prev) check("park_loc", 32'(loc), 32'hF);
            if (done) done_cnt++;
        end
        en_prev = en;
    end

    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (en2 && !en2_prev) begin
                check("to_sb_has_entry", 32'(q2.size() != 0), 1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    check("to_tile_loc", 32'(loc2), 32'(e.loc));
                    check("to_tile_col", 32'(col2), 32'(e.col));
                end
            end
            if (!en2 && en2_prev) check("to_park_loc", 32'(loc2), 32'hF);
            if (done2) done2_cnt++;
        end
        en2_prev = en2;
    end

    task automatic push_exp(input logic [8:0] mask, input logic [26:0] colours, input bit second);
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            if (mask[i]) begin
                e.loc = 4'(i);
                e.col = colours[i*3 +: 3];
                if (second) q2.push_back(e);
                else q1.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_start2();
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic wait_done2(input int budget, input string tag);
        int n = 0;
        while (!done2 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done2), 1);
    endtask

    initial begin
        int d0, n;
        resetn = 1'b0;
        start = 1'b0; tile_colours = '0; redraw_mask = '0;
        start2 = 1'b0; tile_colours2 = '0; redraw_mask2 = '0; fin2 = 1'b0;

        @(negedge clk);
        check("rst_en", 32'(en), 0);
        check("rst_loc", 32'(loc), 32'hF);
        check("rst_col", 32'(col), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_to_loc", 32'(loc2), 32'hF);
        check("rst_to_err", 32'(err2), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: full board
        tile_colours = 27'o012345670; redraw_mask = 9'h1FF;
        d0 = done_cnt;
        push_exp(redraw_mask, tile_colours, 0);
        pulse_start();
        wait_done(15000, "t1_done");
        check("t1_loc_at_done", 32'(loc), 32'hF);
        check("t1_err", 32'(err), 0);
        @(negedge clk);
        check("t1_done_pulse_width", 32'(done), 0);
        check("t1_done_once", 32'(done_cnt - d0), 1);
        check("t1_sb_empty", 32'(q1.size()), 0);

        // 2: sparse board
        tile_colours = 27'o765432107; redraw_mask = 9'b100010001;
        push_exp(redraw_mask, tile_colours, 0);
        pulse_start();
        wait_done(6000, "t2_done");
        check("t2_loc_at_done", 32'(loc), 32'hF);
        @(negedge clk);
        check("t2_sb_empty", 32'(q1.size()), 0);

        // 3: empty mask; done exactly 10 cycles after the start edge
        redraw_mask = 9'h000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check("t3_busy", 32'(busy), 1);
            check("t3_done_timing", 32'(done), (k == 10) ? 1 : 0);
            check("t3_no_enable", 32'(en), 0);
            if (k < 10) @(negedge clk);
        end
        @(negedge clk);
        check("t3_idle_busy", 32'(busy), 0);

        // 4: timeout on the TIMEOUT=16 instance
        tile_colours2 = 27'o000000054; redraw_mask2 = 9'h003;
        push_exp(redraw_mask2, tile_colours2, 1);
        pulse_start2();
        n = 0;
        while (!en2 && n < 50) begin @(negedge clk); n++; end
        check("t4_enable_seen", 32'(en2), 1);
        n = 0;
        while (en2 && n < 100) begin n++; @(negedge clk); end
        check("t4_draw_cycles", 32'(n), 16);
        check("t4_err_set", 32'(err2), 1);
        wait_done2(100, "t4_done");
        check("t4_err_at_done", 32'(err2), 1);
        check("t4_sb_empty", 32'(q2.size()), 0);
        redraw_mask2 = 9'h000;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        check("t4_err_cleared", 32'(err2), 0);
        wait_done2(20, "t4_empty_done");

        // 4b: finished arrives in the very cycle the watchdog expires
        redraw_mask2 = 9'h001;
        push_exp(redraw_mask2, tile_colours2, 1);
        pulse_start2();
        n = 0;
        while (!en2 && n < 50) begin @(negedge clk); n++; end
        repeat (15) @(negedge clk);
        fin2 = 1'b1;
        @(negedge clk);
        fin2 = 1'b0;
        check("t4b_enable_dropped", 32'(en2), 0);
        check("t4b_no_err", 32'(err2), 0);
        wait_done2(20, "t4b_done");
        check("t4b_err_at_done", 32'(err2), 0);

        // 5: start while busy and input changes are ignored
        tile_colours = 27'o111222333; redraw_mask = 9'b000001110;
        d0 = done_cnt;
        push_exp(redraw_mask, tile_colours, 0);
        pulse_start();
        n = 0;
        while (!(en && loc == 4'd2) && n < 4000) begin @(negedge clk); n++; end
        check("t5_reached_tile2", 32'(loc), 32'd2);
        tile_colours = 27'o777777777; redraw_mask = 9'h1FF;
        pulse_start();
        wait_done(6000, "t5_done");
        repeat (20) @(negedge clk);
        check("t5_no_restart", 32'(busy), 0);
        check("t5_done_once", 32'(done_cnt - d0), 1);
        check("t5_sb_empty", 32'(q1.size()), 0);

        // 6: reset mid-DRAW on tile 4
        tile_colours = 27'o123456701; redraw_mask = 9'h1FF;
        push_exp(redraw_mask, tile_colours, 0);
        pulse_start();
        n = 0;
        while (!(en && loc == 4'd4) && n < 8000) begin @(negedge clk); n++; end
        check("t6_reached_tile4", 32'(loc), 32'd4);
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        check("t6_rst_en", 32'(en), 0);
        check("t6_rst_loc", 32'(loc), 32'hF);
        check("t6_rst_col", 32'(col), 0);
        check("t6_rst_busy", 32'(busy), 0);
        q1.delete();
        repeat (3) @(negedge clk);
        check("t6_rst_done", 32'(done), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_done", 32'(done_cnt - d0), 0);
        redraw_mask = 9'b000010001;
        push_exp(redraw_mask, tile_colours, 0);
        pulse_start();
        wait_done(4000, "t6_done");
        @(negedge clk);
        check("t6_sb_empty", 32'(q1.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
